// File: rtl/stopwatch_counter_pkg.sv
// Shared constants and types for the stopwatch counter.
//   CLR_CODE     : panel command code that clears the count
//   DIGIT_W      : width of one BCD digit
//   CS_MAX       : upper limit of the 0..9 digits
//   SEC_TENS_MAX : upper limit of the seconds tens digit (0..5)
package stopwatch_counter_pkg;

  localparam int unsigned DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] bcd_digit_t;

  localparam logic [2:0] CLR_CODE     = 3'd2;
  localparam bcd_digit_t CS_MAX       = 4'd9;
  localparam bcd_digit_t SEC_TENS_MAX = 4'd5;

endpackage

// File: rtl/stopwatch_counter_digit.sv
// One BCD digit that counts 0..MAX and wraps to 0.
// Ports:
//   clk_100 : clock, rising edge
//   rst_n   : asynchronous active-low reset
//   clr     : synchronous clear, wins over inc
//   inc     : advance the digit by one this cycle
//   digit   : current digit value
//   carry   : combinational, high when this increment wraps the digit
module bcd_digit_counter
  import stopwatch_counter_pkg::*;
#(
  parameter bcd_digit_t MAX = CS_MAX
) (
  input  logic       clk_100,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       inc,
  output logic [3:0] digit,
  output logic       carry
);

  bcd_digit_t r_digit;

  // Combinational so that a single tick ripples through the whole chain
  // within one cycle (59.99 -> 00.00 in one edge).
  assign carry = inc && (r_digit == MAX);
  assign digit = r_digit;

  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      r_digit <= '0;
    end else if (clr) begin
      r_digit <= '0;
    end else if (inc) begin
      r_digit <= (r_digit == MAX) ? '0 : r_digit + 4'd1;
    end
  end

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch counter: a prescaled SS.CC BCD live count with a lap-hold
// display register stage.
// Ports:
//   clk_100       : clock, rising edge
//   rst_n         : asynchronous active-low reset
//   reset         : panel command; CLR_CODE clears everything, others ignored
//   start_enable  : 1 = count, 0 = freeze live count and prescaler
//   resume_enable : 1 = display tracks live count, 0 = display held (lap)
//   sec_tens/sec_ones/cs_tens/cs_ones : displayed BCD digits
//   running       : registered start_enable
//   wrap          : one-cycle pulse when the live count rolls 59.99 -> 00.00
module stopwatch_counter
  import stopwatch_counter_pkg::*;
#(
  parameter int unsigned TICKS_PER_CS = 1
) (
  input  logic       clk_100,
  input  logic       rst_n,
  input  logic [2:0] reset,
  input  logic       start_enable,
  input  logic       resume_enable,
  output logic [3:0] sec_tens,
  output logic [3:0] sec_ones,
  output logic [3:0] cs_tens,
  output logic [3:0] cs_ones,
  output logic       running,
  output logic       wrap
);

  localparam logic [7:0] PRESC_TC = 8'(TICKS_PER_CS - 1);

  logic       w_clr;
  logic       w_tick;
  logic [7:0] r_presc;

  logic [3:0] w_live_cs_ones;
  logic [3:0] w_live_cs_tens;
  logic [3:0] w_live_sec_ones;
  logic [3:0] w_live_sec_tens;
  logic       w_carry_cs_ones;
  logic       w_carry_cs_tens;
  logic       w_carry_sec_ones;
  logic       w_carry_sec_tens;

  logic [3:0] r_disp_cs_ones;
  logic [3:0] r_disp_cs_tens;
  logic [3:0] r_disp_sec_ones;
  logic [3:0] r_disp_sec_tens;
  logic       r_running;
  logic       r_wrap;

  assign w_clr  = (reset == CLR_CODE);
  assign w_tick = start_enable && (r_presc == PRESC_TC);

  // Prescaler only moves while counting, so a stop/start keeps the
  // partial centisecond.
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      r_presc <= '0;
    end else if (w_clr) begin
      r_presc <= '0;
    end else if (start_enable) begin
      r_presc <= w_tick ? 8'd0 : r_presc + 8'd1;
    end
  end

  bcd_digit_counter #(.MAX(CS_MAX)) u_cs_ones (
    .clk_100 (clk_100),
    .rst_n   (rst_n),
    .clr     (w_clr),
    .inc     (w_tick),
    .digit   (w_live_cs_ones),
    .carry   (w_carry_cs_ones)
  );

  bcd_digit_counter #(.MAX(CS_MAX)) u_cs_tens (
    .clk_100 (clk_100),
    .rst_n   (rst_n),
    .clr     (w_clr),
    .inc     (w_carry_cs_ones),
    .digit   (w_live_cs_tens),
    .carry   (w_carry_cs_tens)
  );

  bcd_digit_counter #(.MAX(CS_MAX)) u_sec_ones (
    .clk_100 (clk_100),
    .rst_n   (rst_n),
    .clr     (w_clr),
    .inc     (w_carry_cs_tens),
    .digit   (w_live_sec_ones),
    .carry   (w_carry_sec_ones)
  );

  bcd_digit_counter #(.MAX(SEC_TENS_MAX)) u_sec_tens (
    .clk_100 (clk_100),
    .rst_n   (rst_n),
    .clr     (w_clr),
    .inc     (w_carry_sec_ones),
    .digit   (w_live_sec_tens),
    .carry   (w_carry_sec_tens)
  );

  // Display stage samples the registered live count, so it trails the
  // live count by one cycle and freezes while resume_enable is low.
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      r_disp_cs_ones  <= '0;
      r_disp_cs_tens  <= '0;
      r_disp_sec_ones <= '0;
      r_disp_sec_tens <= '0;
    end else if (w_clr) begin
      r_disp_cs_ones  <= '0;
      r_disp_cs_tens  <= '0;
      r_disp_sec_ones <= '0;
      r_disp_sec_tens <= '0;
    end else if (resume_enable) begin
      r_disp_cs_ones  <= w_live_cs_ones;
      r_disp_cs_tens  <= w_live_cs_tens;
      r_disp_sec_ones <= w_live_sec_ones;
      r_disp_sec_tens <= w_live_sec_tens;
    end
  end

  // The last carry of the chain is exactly the 59.99 -> 00.00 event.
  always_ff @(posedge clk_100 or negedge rst_n) begin
    if (!rst_n) begin
      r_running <= 1'b0;
      r_wrap    <= 1'b0;
    end else begin
      r_running <= start_enable;
      r_wrap    <= w_carry_sec_tens && !w_clr;
    end
  end

  assign sec_tens = r_disp_sec_tens;
  assign sec_ones = r_disp_sec_ones;
  assign cs_tens  = r_disp_cs_tens;
  assign cs_ones  = r_disp_cs_ones;
  assign running  = r_running;
  assign wrap     = r_wrap;

endmodule

// File: tb/tb_stopwatch_counter.sv
module tb_stopwatch_counter;

  logic       clk_100 = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] reset_code = 3'd0;
  logic       start_enable = 1'b0;
  logic       resume_enable = 1'b0;

  logic [3:0] st_a, so_a, ct_a, co_a;
  logic       run_a, wrap_a;
  logic [3:0] st_b, so_b, ct_b, co_b;
  logic       run_b, wrap_b;

  always #5 clk_100 = ~clk_100;

  stopwatch_counter #(.TICKS_PER_CS(1)) dut_a (
    .clk_100(clk_100), .rst_n(rst_n), .reset(reset_code),
    .start_enable(start_enable), .resume_enable(resume_enable),
    .sec_tens(st_a), .sec_ones(so_a), .cs_tens(ct_a), .cs_ones(co_a),
    .running(run_a), .wrap(wrap_a)
  );

  stopwatch_counter #(.TICKS_PER_CS(4)) dut_b (
    .clk_100(clk_100), .rst_n(rst_n), .reset(reset_code),
    .start_enable(start_enable), .resume_enable(resume_enable),
    .sec_tens(st_b), .sec_ones(so_b), .cs_tens(ct_b), .cs_ones(co_b),
    .running(run_b), .wrap(wrap_b)
  );

  typedef struct {
    int disp;
    bit run;
    bit wrp;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];

  int total = 0;
  int bad = 0;

  // Reference model: live time kept as plain centiseconds 0..5999.
  int live[2];
  int disp[2];
  int presc[2];
  int tpc[2];
  int n_wraps;

  function automatic logic [15:0] pack_bcd(input int v);
    logic [15:0] r;
    r = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int want);
    total++;
    if (act != want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h at t=%0t", nm, act, want, $time);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      live[k] = 0;
      disp[k] = 0;
      presc[k] = 0;
    end
  endtask

  task automatic step(input bit clr, input bit se, input bit re);
    for (int k = 0; k < 2; k++) begin
      exp_t e;
      int nd;
      bit w;
      w = 1'b0;
      nd = clr ? 0 : (re ? live[k] : disp[k]);
      if (clr) begin
        live[k] = 0;
        presc[k] = 0;
      end else if (se) begin
        if (presc[k] == tpc[k] - 1) begin
          presc[k] = 0;
          if (live[k] == 5999) begin
            live[k] = 0;
            w = 1'b1;
          end else begin
            live[k] = live[k] + 1;
          end
        end else begin
          presc[k] = presc[k] + 1;
        end
      end
      disp[k] = nd;
      e.disp = nd;
      e.run = se;
      e.wrp = w;
      if (k == 0) begin
        q_a.push_back(e);
        if (w) n_wraps++;
      end else begin
        q_b.push_back(e);
      end
    end
  endtask

  task automatic cyc(input logic [2:0] code, input bit se, input bit re);
    @(negedge clk_100);
    #1;
    reset_code = code;
    start_enable = se;
    resume_enable = re;
    step(code == 3'd2, se, re);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_disp_a"}, {st_a, so_a, ct_a, co_a}, 0);
    chk({tag, "_run_a"}, run_a, 0);
    chk({tag, "_wrap_a"}, wrap_a, 0);
    chk({tag, "_disp_b"}, {st_b, so_b, ct_b, co_b}, 0);
    chk({tag, "_run_b"}, run_b, 0);
    chk({tag, "_wrap_b"}, wrap_b, 0);
  endtask

  // Asynchronous reset pulse placed between edges.
  task automatic rst_pulse(input bit se, input bit re);
    @(negedge clk_100);
    #1;
    reset_code = 3'd0;
    start_enable = se;
    resume_enable = re;
    rst_n = 1'b0;
    #1;
    chk_zero("async_rst");
    #1;
    rst_n = 1'b1;
    model_reset();
    step(1'b0, se, re);
  endtask

  // Monitor: every negedge, compare against whatever the model queued.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_100);
      if (q_a.size() > 0) begin
        e = q_a.pop_front();
        chk("disp_a", {st_a, so_a, ct_a, co_a}, pack_bcd(e.disp));
        chk("run_a", run_a, e.run);
        chk("wrap_a", wrap_a, e.wrp);
      end
      if (q_b.size() > 0) begin
        e = q_b.pop_front();
        chk("disp_b", {st_b, so_b, ct_b, co_b}, pack_bcd(e.disp));
        chk("run_b", run_b, e.run);
        chk("wrap_b", wrap_b, e.wrp);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog got=timeout want=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0] c;
    tpc[0] = 1;
    tpc[1] = 4;
    n_wraps = 0;
    model_reset();

    #12;
    chk_zero("por");

    @(negedge clk_100);
    #1;
    rst_n = 1'b1;
    step(1'b0, 1'b0, 1'b0);

    // Straight run from reset, then a lap hold and release.
    repeat (150) cyc(3'd0, 1'b1, 1'b1);
    repeat (30) cyc(3'd0, 1'b1, 1'b0);
    repeat (5) cyc(3'd0, 1'b1, 1'b1);

    // Stop/start pattern for the prescaled instance.
    repeat (10) cyc(3'd0, 1'b1, 1'b1);
    repeat (20) cyc(3'd0, 1'b0, 1'b1);
    repeat (6) cyc(3'd0, 1'b1, 1'b1);

    // Long random run with no clears so the fast instance wraps.
    repeat (7500) begin
      c = 3'($urandom_range(0, 7));
      if (c == 3'd2) c = 3'd3;
      cyc(c, $urandom_range(0, 9) != 0, $urandom_range(0, 4) != 0);
    end

    rst_pulse(1'b1, 1'b1);
    repeat (40) cyc(3'd0, 1'b1, 1'b1);

    // Clear held over several cycles, then released while counting.
    repeat (3) cyc(3'd2, 1'b1, 1'b1);
    repeat (10) cyc(3'd0, 1'b1, 1'b1);
    cyc(3'd1, 1'b1, 1'b1);

    // Random run with occasional clears.
    repeat (2500) begin
      c = ($urandom_range(0, 29) == 0) ? 3'd2 : 3'($urandom_range(0, 7));
      cyc(c, $urandom_range(0, 5) != 0, $urandom_range(0, 3) != 0);
    end

    rst_pulse(1'b0, 1'b1);
    repeat (20) cyc(3'd0, 1'b1, 1'b1);

    repeat (2) @(negedge clk_100);
    #2;
    chk("queue_drain", q_a.size() + q_b.size(), 0);
    chk("wrap_seen", (n_wraps > 0) ? 1 : 0, 1);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_counter.md
STOPWATCH_COUNTER -- requirements
Module: stopwatch_counter

Interface
REQ-001 Parameter TICKS_PER_CS, default 1; number of clk_100 cycles per centisecond increment (1..255).
REQ-002 clk_100  input  1  system clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 reset  input  3  panel command code; value 3'd2 = clear request, all other codes ignored.
REQ-005 start_enable  input  1  level from the stopwatch state FSM; 1 = counting, 0 = stopped.
REQ-006 resume_enable  input  1  level from the state FSM; 1 = display follows count, 0 = display held (lap).
REQ-007 sec_tens  output  4  BCD displayed seconds tens, 0..5.
REQ-008 sec_ones  output  4  BCD displayed seconds ones, 0..9.
REQ-009 cs_tens  output  4  BCD displayed centiseconds tens, 0..9.
REQ-010 cs_ones  output  4  BCD displayed centiseconds ones, 0..9.
REQ-011 running  output  1  registered copy of start_enable.
REQ-012 wrap  output  1  one-cycle pulse when the live count rolls over 59.99 -> 00.00.

Function
REQ-013 Prescaler SHALL count clk_100 cycles while start_enable=1 and issue one tick on reaching TICKS_PER_CS-1, then return to 0.
REQ-014 Prescaler SHALL hold its value while start_enable=0; no tick is issued.
REQ-015 Each tick SHALL increment the live count (4 BCD digits, SS.CC) by one centisecond, with decimal carries cs_ones 9->0, cs_tens 9->0, sec_ones 9->0, sec_tens 5->0.
REQ-016 Live value 59.99 plus a tick SHALL yield 00.00 and assert wrap for exactly that one cycle.
REQ-017 Live count SHALL update on the clock edge at which the tick is registered; no further pipeline delay.
REQ-018 Display registers SHALL load the next live value on every cycle with resume_enable=1, giving display = live count with one-cycle latency.
REQ-019 Display registers SHALL hold while resume_enable=0; live count continues per REQ-013..016.
REQ-020 Return of resume_enable to 1 SHALL make display catch up to live on the next cycle.
REQ-021 reset==3'd2 SHALL, on the next edge, clear live count, prescaler, display registers and wrap to 0, regardless of start_enable/resume_enable.
REQ-022 Clear and tick in the same cycle: clear SHALL win, with the result 00.00 and wrap=0.
REQ-023 Clear held for multiple cycles SHALL keep all counts at 0; counting resumes on the first cycle after release if start_enable=1.
REQ-024 start_enable 1->0 mid-count SHALL freeze live count and prescaler; 0->1 SHALL continue from the frozen values.
REQ-025 All BCD digits SHALL remain in their legal ranges at all times; no illegal code is reachable.

Reset
REQ-026 rst_n low SHALL immediately force live count, display digits, prescaler, running and wrap to 0.
REQ-027 rst_n deassertion mid-operation SHALL restart from 00.00, stopped until start_enable=1.

Structure
REQ-028 Shared package SHALL hold CLR_CODE (3'd2), digit limits (CS_MAX=9, SEC_TENS_MAX=5) and the BCD digit width (4).
REQ-029 Sub-module bcd_digit_counter (parameter MAX; inputs clk_100, rst_n, clr, inc; outputs digit[3:0], carry) SHALL be instantiated four times, chained by carry.
REQ-030 carry SHALL be combinational (inc && digit==MAX) so the full chain rolls over in one cycle.

Verification
REQ-031 TICKS_PER_CS=1, start_enable=1 for 150 cycles from reset -> display 01.49 one cycle after the last tick; running=1.
REQ-032 Preload by running to 59.98, then two ticks -> live 00.00 after the second tick, wrap high for exactly one cycle.
REQ-033 At 00.20, resume_enable=0 for 30 cycles, then 1 -> display holds 00.20 during the hold, shows 00.50 on the first cycle after release.
REQ-034 TICKS_PER_CS=4, start_enable=1 for 10 cycles, 0 for 20, 1 for 6 -> live 00.04 (16 cycles counted), prescaler preserved across the stop.
REQ-035 reset=3'd2 asserted on the same cycle as a tick at 12.34 -> all digits 0, wrap=0 next cycle; reset=3'd1 at the same point -> no effect.
REQ-036 rst_n pulsed low asynchronously between edges at 33.33 -> outputs 0 immediately, no count until the next rising edge after release with start_enable=1.
